// File: rtl/adc_pipe_corrector_if.sv
// rtl/adc_pipe_corrector_if.sv - skewed stage-code input bundle for the ADC correction back end
interface adc_pipe_corrector_if #(
  parameter int NUM_STAGES         = 2,
  parameter int NUM_BITS_PER_STAGE = 2,
  parameter int BITS_ADC_STAGE     = 1
);
  logic                                       valid_i;
  logic [NUM_STAGES*NUM_BITS_PER_STAGE-1:0]   d_stage_i;
  logic [BITS_ADC_STAGE-1:0]                  d_last_stage_i;

  modport master (output valid_i, d_stage_i, d_last_stage_i);
  modport slave  (input  valid_i, d_stage_i, d_last_stage_i);
endinterface

// File: rtl/adc_pipe_corrector.sv
// rtl/adc_pipe_corrector.sv - pipelined ADC digital error correction with saturation, error count and averaging
module adc_pipe_corrector #(
  parameter int  NUM_STAGES         = 2,
  parameter int  NUM_BITS_PER_STAGE = 2,
  parameter int  REDUNDANCY         = 1,
  parameter int  BITS_ADC_STAGE     = 1,
  parameter int  AVG_LOG2           = 2,
  parameter int  ERR_CNT_W          = 8,
  localparam int NUM_BITS = NUM_STAGES*(NUM_BITS_PER_STAGE-REDUNDANCY)+BITS_ADC_STAGE
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clr_err_i,
  adc_pipe_corrector_if.slave  in_if,
  output logic [NUM_BITS-1:0]  d_o,
  output logic                 valid_o,
  output logic                 ovr_o,
  output logic                 err_o,
  output logic [NUM_BITS-1:0]  avg_o,
  output logic                 avg_valid_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  localparam int B     = NUM_BITS_PER_STAGE;
  localparam int SUM_W = NUM_BITS + B;
  localparam int AVG_W = NUM_BITS + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SUM_W-1:0] SAT_SUM  = {{B{1'b0}}, {NUM_BITS{1'b1}}};

  function automatic logic [SUM_W-1:0] weigh(input logic [B-1:0] code, input int sh);
    return SUM_W'(code) << sh;
  endfunction

  function automatic logic illegal(input logic [B-1:0] code);
    return (REDUNDANCY > 0) && (code == {B{1'b1}});
  endfunction

  // Index k holds the partial sum of a sample once stages 0..k have been added in.
  logic [SUM_W-1:0]    acc_q [NUM_STAGES+1];
  logic [SUM_W-1:0]    acc_d [NUM_STAGES+1];
  logic [NUM_STAGES:0] vld_q, vld_d, tag_q, tag_d;

  logic [NUM_BITS-1:0]  dout_q, dout_d, avg_q, avg_d;
  logic                 vout_q, vout_d, ovr_q, ovr_d, err_q, err_d, avgv_q, avgv_d;
  logic [AVG_W-1:0]     avg_acc_q, avg_acc_d, avg_sum;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sat;

  always_comb begin
    acc_d = acc_q;
    vld_d = vld_q;
    tag_d = tag_q;
    acc_d[0] = weigh(in_if.d_stage_i[0 +: B],
                     (NUM_STAGES-1)*(B-REDUNDANCY) + BITS_ADC_STAGE - REDUNDANCY);
    vld_d[0] = in_if.valid_i;
    tag_d[0] = illegal(in_if.d_stage_i[0 +: B]);
    for (int k = 1; k < NUM_STAGES; k++) begin
      acc_d[k] = acc_q[k-1] + weigh(in_if.d_stage_i[k*B +: B],
                     (NUM_STAGES-1-k)*(B-REDUNDANCY) + BITS_ADC_STAGE - REDUNDANCY);
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1] | illegal(in_if.d_stage_i[k*B +: B]);
    end
    acc_d[NUM_STAGES] = acc_q[NUM_STAGES-1] + SUM_W'(in_if.d_last_stage_i);
    vld_d[NUM_STAGES] = vld_q[NUM_STAGES-1];
    tag_d[NUM_STAGES] = tag_q[NUM_STAGES-1];
  end

  always_comb begin
    sat    = acc_q[NUM_STAGES] > SAT_SUM;
    dout_d = dout_q;
    ovr_d  = ovr_q;
    err_d  = err_q;
    vout_d = vld_q[NUM_STAGES];
    if (vld_q[NUM_STAGES]) begin
      dout_d = sat ? {NUM_BITS{1'b1}} : acc_q[NUM_STAGES][NUM_BITS-1:0];
      ovr_d  = sat;
      err_d  = tag_q[NUM_STAGES];
    end
  end

  // The averager and error counter consume the registered outputs, one edge after valid_o rises.
  always_comb begin
    avg_sum   = avg_acc_q + AVG_W'(dout_q);
    avg_d     = avg_q;
    avgv_d    = 1'b0;
    avg_acc_d = avg_acc_q;
    cnt_d     = cnt_q;
    if (vout_q) begin
      if (cnt_q == CNT_LAST) begin
        avg_d     = NUM_BITS'(avg_sum >> AVG_LOG2);
        avgv_d    = 1'b1;
        avg_acc_d = '0;
        cnt_d     = '0;
      end else begin
        avg_acc_d = avg_sum;
        cnt_d     = cnt_q + 1'b1;
      end
    end
    err_cnt_d = err_cnt_q;
    if (clr_err_i) begin
      err_cnt_d = '0;
    end else if (vout_q && err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i <= NUM_STAGES; i++) acc_q[i] <= '0;
      vld_q     <= '0;
      tag_q     <= '0;
      dout_q    <= '0;
      vout_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      avg_q     <= '0;
      avgv_q    <= 1'b0;
      avg_acc_q <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
      avg_q     <= avg_d;
      avgv_q    <= avgv_d;
      avg_acc_q <= avg_acc_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign d_o         = dout_q;
  assign valid_o     = vout_q;
  assign ovr_o       = ovr_q;
  assign err_o       = err_q;
  assign avg_o       = avg_q;
  assign avg_valid_o = avgv_q;
  assign err_cnt_o   = err_cnt_q;
endmodule
